// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, transaction owner
// and the default watchdog limit.
package mem_arb_pkg;

   localparam int STATE_SIZE      = 2;
   localparam int TIMEOUT_DEFAULT = 255;

   typedef enum logic [STATE_SIZE-1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises icache refills and data-side loads/stores onto one memory port,
// one transaction in flight, round-robin on contention, watchdog on hung responses.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ic_req,
   input  logic [ADDR_W-1:0]   ic_addr,
   output logic [DATA_W-1:0]   ic_data,
   output logic                ic_valid,
   output logic                ic_err,
   input  logic                dc_req,
   input  logic                dc_we,
   input  logic [ADDR_W-1:0]   dc_addr,
   input  logic [DATA_W-1:0]   dc_wdata,
   input  logic [DATA_W/8-1:0] dc_wstrb,
   output logic [DATA_W-1:0]   dc_rdata,
   output logic                dc_valid,
   output logic                dc_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_ready,
   input  logic                mem_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t              state, state_nx;
   owner_t              owner, last_owner, win;
   logic [CNT_W-1:0]    cnt;
   logic                timed_out;
   logic                any_req;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;

   // On a tie the side that was not served last goes first.
   function automatic owner_t rr_grant(input logic ic, input logic dc, input owner_t last);
      if (ic && dc) return (last == OWN_IC) ? OWN_DC : OWN_IC;
      return dc ? OWN_DC : OWN_IC;
   endfunction

   assign any_req   = ic_req || dc_req;
   assign win       = rr_grant(ic_req, dc_req, last_owner);
   assign timed_out = (cnt == CNT_W'(TIMEOUT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (any_req)                state_nx = ST_ISSUE;
         ST_ISSUE: if (mem_ready)              state_nx = ST_WAIT;
         ST_WAIT:  if (mem_valid || timed_out) state_nx = ST_RESP;
         default:                              state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req  = (state == ST_ISSUE);
      ic_valid = (state == ST_RESP) && (owner == OWN_IC);
      dc_valid = (state == ST_RESP) && (owner == OWN_DC);
      ic_err   = ic_valid && err_q;
      dc_err   = dc_valid && err_q;
   end

   // Payload, owner, watchdog and response capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner      <= OWN_IC;
         last_owner <= OWN_IC;
         cnt        <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: if (any_req) begin
               owner <= win;
               if (win == OWN_DC) begin
                  we_q    <= dc_we;
                  addr_q  <= dc_addr;
                  wdata_q <= dc_wdata;
                  wstrb_q <= dc_wstrb;
               end else begin
                  we_q    <= 1'b0;
                  addr_q  <= ic_addr;
                  wdata_q <= '0;
                  wstrb_q <= '0;
               end
            end
            ST_ISSUE: if (mem_ready) cnt <= '0;
            ST_WAIT: begin
               // A response landing on the final watchdog cycle still counts.
               if (mem_valid) begin
                  rdata_q <= mem_rdata;
                  err_q   <= 1'b0;
               end else if (timed_out) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: last_owner <= owner;
         endcase
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;
   assign ic_data   = rdata_q;
   assign dc_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: transaction-level arbitration model,
// memory responder with random stalls/latencies, directed corner cases first.
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ic_req = 1'b0;
   logic [AW-1:0] ic_addr = '0;
   logic [DW-1:0] ic_data;
   logic          ic_valid, ic_err;
   logic          dc_req = 1'b0;
   logic          dc_we = 1'b0;
   logic [AW-1:0] dc_addr = '0;
   logic [DW-1:0] dc_wdata = '0;
   logic [3:0]    dc_wstrb = '0;
   logic [DW-1:0] dc_rdata;
   logic          dc_valid, dc_err;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_wstrb;
   logic          mem_ready, mem_valid;
   logic [DW-1:0] mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_valid(ic_valid), .ic_err(ic_err),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb),
      .dc_rdata(dc_rdata), .dc_valid(dc_valid), .dc_err(dc_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
   );

   typedef struct { logic dc; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } txn_t;
   typedef struct { logic dc; logic we; logic [31:0] data; logic err; int cyc; } resp_t;

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   resp_t rq[$];

   // memory knobs (main) and next-response choice (memory process)
   bit          fix_mode = 1'b1;
   bit          rdy_rand = 1'b0;
   int          fix_lat = 1;
   int          stall_n = 0;
   logic [31:0] fix_data = '0;
   int          next_lat = 1;
   logic [31:0] next_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, " mem_req"},   32'(mem_req),   0);
      chk({pfx, " mem_we"},    32'(mem_we),    0);
      chk({pfx, " mem_addr"},  mem_addr,       0);
      chk({pfx, " mem_wdata"}, mem_wdata,      0);
      chk({pfx, " mem_wstrb"}, 32'(mem_wstrb), 0);
      chk({pfx, " ic_valid"},  32'(ic_valid),  0);
      chk({pfx, " dc_valid"},  32'(dc_valid),  0);
      chk({pfx, " ic_err"},    32'(ic_err),    0);
      chk({pfx, " dc_err"},    32'(dc_err),    0);
      chk({pfx, " ic_data"},   ic_data,        0);
      chk({pfx, " dc_rdata"},  dc_rdata,       0);
   endtask

   // Transaction-level model: who should be granted, and what the memory owes back.
   initial begin : model
      bit   busy, iss, last_dc;
      txn_t g;
      resp_t r;
      busy = 0; iss = 0; last_dc = 0;
      g = '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
      forever begin
         @(negedge clk);
         if (!rst) begin
            busy = 0; iss = 0; last_dc = 0;
            rq.delete();
         end else begin
            chk("mem_req", 32'(mem_req), 32'(iss));
            if (iss && mem_req) begin
               checks++;
               if (mem_we !== g.we || mem_addr !== g.addr || mem_wstrb !== g.wstrb ||
                   (g.we && mem_wdata !== g.wdata)) begin
                  failures++;
                  $display("FAIL payload cyc=%0d got we=%b a=%h d=%h s=%h exp we=%b a=%h d=%h s=%h",
                           cyc, mem_we, mem_addr, mem_wdata, mem_wstrb, g.we, g.addr, g.wdata, g.wstrb);
               end
               if (mem_ready) begin
                  r.dc = g.dc; r.we = g.we;
                  if (next_lat >= 1 && next_lat <= TMO + 1) begin
                     r.data = next_data; r.err = 1'b0; r.cyc = cyc + next_lat + 1;
                  end else begin
                     r.data = '0; r.err = 1'b1; r.cyc = cyc + TMO + 2;
                  end
                  rq.push_back(r);
                  iss = 0;
               end
            end
            if (!busy && (ic_req || dc_req)) begin
               g.dc = (ic_req && dc_req) ? !last_dc : dc_req;
               last_dc = g.dc;
               if (g.dc) g = '{1'b1, dc_we, dc_addr, dc_wdata, dc_wstrb};
               else      g = '{1'b0, 1'b0, ic_addr, 32'h0, 4'h0};
               busy = 1; iss = 1;
            end
            if (ic_valid || dc_valid) busy = 0;
         end
      end
   end

   // Response monitor: every completion pulse must match the head of the scoreboard.
   initial begin : monitor
      resp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (ic_valid || dc_valid) begin
               chk("one valid", 32'(ic_valid && dc_valid), 0);
               if (rq.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected valid cyc=%0d got ic=%b dc=%b exp none", cyc, ic_valid, dc_valid);
               end else begin
                  e = rq.pop_front();
                  chk("resp owner", 32'(dc_valid), 32'(e.dc));
                  chk("resp cycle", cyc, e.cyc);
                  chk("resp err", 32'(dc_valid ? dc_err : ic_err), 32'(e.err));
                  if (!e.we) chk("resp data", dc_valid ? dc_rdata : ic_data, e.data);
               end
            end else if (rq.size() != 0 && cyc > rq[0].cyc) begin
               checks++; failures++;
               $display("FAIL missing valid cyc=%0d got none exp at cyc=%0d", cyc, rq[0].cyc);
               void'(rq.pop_front());
            end
         end
      end
   end

   // Memory responder.
   initial begin : memory
      int lat_left, hold, r;
      logic [31:0] cur;
      lat_left = 0; hold = 0; cur = '0;
      mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_valid = 1'b0;
         mem_rdata = $urandom;
         if (lat_left > 0) begin
            lat_left--;
            if (lat_left == 0) begin mem_valid = 1'b1; mem_rdata = cur; end
         end
         if (fix_mode) begin
            next_lat = fix_lat; next_data = fix_data;
         end else begin
            r = $urandom_range(0, 9);
            next_lat  = (r == 0) ? 0 : (r == 1) ? TMO + 1 : (r == 2) ? TMO + 2 : $urandom_range(1, TMO);
            next_data = $urandom;
         end
         if (rdy_rand) mem_ready = ($urandom_range(0, 2) != 0);
         else          mem_ready = (hold >= stall_n);
         if (mem_req && !mem_ready) hold++;
         @(negedge clk);
         if (!rst) begin
            lat_left = 0; hold = 0;
         end else if (mem_req && mem_ready) begin
            lat_left = next_lat; cur = next_data; hold = 0;
         end
      end
   end

   task automatic wait_any(input int lim, output bit ok, output bit is_dc, output int c,
                           output logic [31:0] d, output logic e);
      ok = 0; is_dc = 0; c = 0; d = '0; e = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (ic_valid || dc_valid) begin
            ok = 1; is_dc = dc_valid; c = cyc;
            d = dc_valid ? dc_rdata : ic_data;
            e = dc_valid ? dc_err : ic_err;
            break;
         end
      end
   endtask

   task automatic one(input bit dc, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_dly, input logic [31:0] exp_d, input logic exp_e, input string nm);
      int t0, c;
      bit ok, isdc;
      logic [31:0] d;
      logic e;
      @(posedge clk); #1;
      t0 = cyc;
      if (dc) begin
         dc_req = 1'b1; dc_we = we; dc_addr = addr; dc_wdata = wdata; dc_wstrb = we ? 4'hF : 4'h0;
      end else begin
         ic_req = 1'b1; ic_addr = addr;
      end
      wait_any(60, ok, isdc, c, d, e);
      #1; ic_req = 1'b0; dc_req = 1'b0;
      chk({nm, " seen"}, 32'(ok), 1);
      chk({nm, " owner"}, 32'(isdc), 32'(dc));
      chk({nm, " latency"}, c - t0, exp_dly);
      chk({nm, " err"}, 32'(e), 32'(exp_e));
      if (!we) chk({nm, " data"}, d, exp_d);
   endtask

   task automatic step_req(input bit en);
      if (ic_req) begin
         if (ic_valid) begin
            if (en && $urandom_range(0, 1) == 1) ic_addr = $urandom;
            else ic_req = 1'b0;
         end
      end else if (en && $urandom_range(0, 2) == 0) begin
         ic_req = 1'b1; ic_addr = $urandom;
      end
      if (dc_req) begin
         if (dc_valid) begin
            if (en && $urandom_range(0, 1) == 1) begin
               dc_we = 1'($urandom_range(0, 1)); dc_addr = $urandom; dc_wdata = $urandom;
               dc_wstrb = dc_we ? 4'($urandom_range(1, 15)) : 4'h0;
            end else dc_req = 1'b0;
         end
      end else if (en && $urandom_range(0, 2) == 0) begin
         dc_req = 1'b1; dc_we = 1'($urandom_range(0, 1)); dc_addr = $urandom; dc_wdata = $urandom;
         dc_wstrb = dc_we ? 4'($urandom_range(1, 15)) : 4'h0;
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog cyc=%0d got no finish exp finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int t0, c;
      bit ok, isdc;
      logic [31:0] d;
      logic e;

      #1 rst = 1'b0;
      #1 chk_reset("reset");
      #20 rst = 1'b1;

      // simultaneous requests from reset: DC first, then strict alternation
      fix_mode = 1; fix_lat = 1; fix_data = 32'h5555_AAAA; stall_n = 0;
      @(posedge clk); #1;
      t0 = cyc;
      ic_req = 1'b1; ic_addr = 32'h0000_0100;
      dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0200; dc_wdata = 32'h1234_5678; dc_wstrb = 4'hF;
      for (int n = 0; n < 7; n++) begin
         wait_any(60, ok, isdc, c, d, e);
         chk($sformatf("tie%0d owner", n), 32'(isdc), 32'(n % 2 == 0));
         if (n == 0) chk("tie0 latency", c - t0, 3);
         #1;
         if (!ok) begin ic_req = 1'b0; dc_req = 1'b0; end
         else if (n >= 5) begin
            if (isdc) dc_req = 1'b0; else ic_req = 1'b0;
         end
      end

      fix_data = 32'hDEAD_BEEF;
      one(0, 0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, "ic_single");
      stall_n = 5;
      fix_data = 32'h0F0F_1234;
      one(0, 0, 32'h0000_0140, 32'h0, 8, 32'h0F0F_1234, 1'b0, "ic_stall5");
      stall_n = 0;
      fix_lat = 0;
      one(1, 0, 32'h0000_0400, 32'h0, TMO + 3, 32'h0, 1'b1, "dc_timeout");
      fix_lat = 1; fix_data = 32'h0BAD_F00D;
      one(1, 0, 32'h0000_0404, 32'h0, 3, 32'h0BAD_F00D, 1'b0, "dc_after_timeout");
      fix_lat = TMO + 1; fix_data = 32'hCAFE_F00D;
      one(1, 0, 32'h0000_0408, 32'h0, TMO + 3, 32'hCAFE_F00D, 1'b0, "dc_valid_at_limit");
      fix_lat = 2;
      one(1, 1, 32'h0000_040C, 32'hA5A5_A5A5, 4, 32'h0, 1'b0, "dc_write");

      // reset in the middle of WAIT abandons the transaction
      fix_lat = 0;
      @(posedge clk); #1;
      ic_req = 1'b1; ic_addr = 32'h0000_0180;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1 chk_reset("midwait");
      ic_req = 1'b0;
      @(negedge clk); #2 rst = 1'b1;
      wait_any(15, ok, isdc, c, d, e);
      chk("no stale valid", 32'(ok), 0);

      // randomised traffic against the model
      fix_mode = 0; rdy_rand = 1;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk); #1;
         step_req(1'b1);
      end
      for (int k = 0; k < 300 && (ic_req || dc_req); k++) begin
         @(posedge clk); #1;
         step_req(1'b0);
      end
      chk("drained", 32'(ic_req || dc_req), 0);
      repeat (TMO + 6) @(posedge clk);
      chk("scoreboard empty", rq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
